// File: rtl/mem_reg_pkg.sv
// Shared MEM-stage definitions: memory op codes, bus widths, FSM states and the MEM/WB bundle.
package mem_reg_pkg;

    localparam int OP_W   = 4;
    localparam int WORD_W = 32;
    localparam int GPR_W  = 5;

    typedef enum logic [OP_W-1:0] {
        MEMOP_NOP = 4'd0,
        MEMOP_LW  = 4'd1,
        MEMOP_LH  = 4'd2,
        MEMOP_LHU = 4'd3,
        MEMOP_LB  = 4'd4,
        MEMOP_LBU = 4'd5,
        MEMOP_SW  = 4'd6,
        MEMOP_SH  = 4'd7,
        MEMOP_SB  = 4'd8
    } mem_op_e;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic              en;
        logic [WORD_W-1:0] pc;
        logic [GPR_W-1:0]  dst;
        logic              gpr_we;
        logic [WORD_W-1:0] out;
        logic              exp;
    } mem_wb_t;

    function automatic logic is_load_op(input logic [OP_W-1:0] op);
        return op inside {MEMOP_LW, MEMOP_LH, MEMOP_LHU, MEMOP_LB, MEMOP_LBU};
    endfunction

    function automatic logic is_word_op(input logic [OP_W-1:0] op);
        return op inside {MEMOP_LW, MEMOP_SW};
    endfunction

    function automatic logic is_half_op(input logic [OP_W-1:0] op);
        return op inside {MEMOP_LH, MEMOP_LHU, MEMOP_SH};
    endfunction

endpackage

// File: rtl/mem_misalign_chk.sv
// Combinational alignment checker for word/half accesses; only built with MEM_MISALIGN_EN.
`ifdef MEM_MISALIGN_EN
module mem_misalign_chk
    import mem_reg_pkg::*;
(
    input  logic            en,
    input  logic [OP_W-1:0] op,
    input  logic [1:0]      addr_lo,
    output logic            misalign
);

    always_comb begin
        misalign = en & ((is_word_op(op) & (addr_lo != 2'b00)) |
                         (is_half_op(op) & addr_lo[0]));
    end

endmodule
`endif

// File: rtl/mem_reg.sv
// MEM/WB pipeline register with BRAM load-wait FSM.
// Optional misalignment exception when MEM_MISALIGN_EN is defined.
module mem_reg
    import mem_reg_pkg::*;
#(
    parameter int WAIT_CYC = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_en,
    input  logic [OP_W-1:0]   ex_mem_op,
    input  logic [1:0]        ex_addr_lo,
    input  logic [WORD_W-1:0] ex_pc,
    input  logic [GPR_W-1:0]  ex_dst_addr,
    input  logic              ex_gpr_we,
    input  logic [WORD_W-1:0] mem_out_in,
    output logic              mem_en,
    output logic [WORD_W-1:0] mem_pc,
    output logic [GPR_W-1:0]  mem_dst_addr,
    output logic              mem_gpr_we,
    output logic [WORD_W-1:0] mem_out,
    output logic              mem_busy,
    output logic              mem_exp
);

    // Counter walks 0..WAIT_CYC-1 in LOAD_WAIT; the last value is the exit cycle.
    localparam logic [1:0] CNT_LAST = 2'(WAIT_CYC - 1);
    localparam logic [1:0] CNT_DONE = 2'(WAIT_CYC);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    mem_wb_t    wb_q, wb_d;
    mem_wb_t    cap, bubble;
    logic       misalign;
    logic       load_req;

`ifdef MEM_MISALIGN_EN
    mem_misalign_chk u_misalign_chk (
        .en      (ex_en),
        .op      (ex_mem_op),
        .addr_lo (ex_addr_lo),
        .misalign(misalign)
    );
`else
    logic unused_addr_lo;
    assign unused_addr_lo = ^ex_addr_lo;
    assign misalign       = 1'b0;
`endif

    // A misaligned load faults immediately instead of waiting on the BRAM.
    assign load_req = ex_en & is_load_op(ex_mem_op) & ~misalign;

    always_comb begin
        cap.en     = ex_en;
        cap.pc     = ex_pc;
        cap.dst    = ex_dst_addr;
        cap.gpr_we = ex_en & ex_gpr_we & ~misalign;
        cap.out    = mem_out_in;
        cap.exp    = misalign;

        bubble        = wb_q;
        bubble.en     = 1'b0;
        bubble.gpr_we = 1'b0;
        bubble.exp    = 1'b0;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wb_d     = wb_q;
        mem_busy = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                mem_busy = load_req & ~flush;
                if (!stall && !flush) begin
                    if (load_req) begin
                        state_d = ST_LOAD_WAIT;
                        cnt_d   = 2'd0;
                        wb_d    = bubble;
                    end else begin
                        wb_d = cap;
                    end
                end
            end
            ST_LOAD_WAIT: begin
                mem_busy = (cnt_q != CNT_DONE);
                if (!stall && !flush) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        wb_d    = cap;
                    end else begin
                        wb_d = bubble;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush kills whatever is in flight, including a waiting load.
        if (!stall && flush) begin
            state_d     = ST_IDLE;
            cnt_d       = 2'd0;
            wb_d        = cap;
            wb_d.en     = 1'b0;
            wb_d.gpr_we = 1'b0;
            wb_d.exp    = 1'b0;
        end

        if (rst) mem_busy = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
        end
    end

    assign mem_en       = wb_q.en;
    assign mem_pc       = wb_q.pc;
    assign mem_dst_addr = wb_q.dst;
    assign mem_gpr_we   = wb_q.gpr_we;
    assign mem_out      = wb_q.out;
    // Without MEM_MISALIGN_EN the exp flop only ever loads 0.
    assign mem_exp      = wb_q.exp;

endmodule

// File: tb/tb_mem_reg.sv
// Randomized bench for mem_reg against a countdown transaction model.
module tb_mem_reg;
    import mem_reg_pkg::*;

    localparam int WAIT_CYC = 1;

    logic        clk = 1'b0;
    logic        rst, stall, flush, ex_en, ex_gpr_we;
    logic [3:0]  ex_mem_op;
    logic [1:0]  ex_addr_lo;
    logic [31:0] ex_pc, mem_out_in;
    logic [4:0]  ex_dst_addr;
    logic        mem_en, mem_gpr_we, mem_busy, mem_exp;
    logic [31:0] mem_pc, mem_out;
    logic [4:0]  mem_dst_addr;

    always #5 clk = ~clk;

    mem_reg #(.WAIT_CYC(WAIT_CYC)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_en(ex_en),
        .ex_mem_op(ex_mem_op), .ex_addr_lo(ex_addr_lo), .ex_pc(ex_pc),
        .ex_dst_addr(ex_dst_addr), .ex_gpr_we(ex_gpr_we), .mem_out_in(mem_out_in),
        .mem_en(mem_en), .mem_pc(mem_pc), .mem_dst_addr(mem_dst_addr),
        .mem_gpr_we(mem_gpr_we), .mem_out(mem_out), .mem_busy(mem_busy), .mem_exp(mem_exp)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: registered fields plus edges left before a pending load retires.
    logic        m_en, m_we, m_exp;
    logic [31:0] m_pc, m_out;
    logic [4:0]  m_dst;
    int          m_wait = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    function automatic bit is_ld(input logic [3:0] op);
        return op inside {MEMOP_LW, MEMOP_LH, MEMOP_LHU, MEMOP_LB, MEMOP_LBU};
    endfunction

    function automatic bit misal(input bit e, input logic [3:0] op, input logic [1:0] lo);
`ifdef MEM_MISALIGN_EN
        if (!e) return 0;
        if (op == MEMOP_LW || op == MEMOP_SW) return lo != 2'b00;
        if (op == MEMOP_LH || op == MEMOP_LHU || op == MEMOP_SH) return lo[0];
        return 0;
`else
        return 0;
`endif
    endfunction

    task automatic chk_out();
        chk("en",     32'(mem_en),       32'(m_en));
        chk("pc",     mem_pc,            m_pc);
        chk("dst",    32'(mem_dst_addr), 32'(m_dst));
        chk("gpr_we", 32'(mem_gpr_we),   32'(m_we));
        chk("out",    mem_out,           m_out);
        chk("exp",    32'(mem_exp),      32'(m_exp));
    endtask

    task automatic cyc(input bit r, input bit s, input bit f, input bit e,
                       input logic [3:0] op, input logic [1:0] lo, input logic [31:0] pc,
                       input logic [4:0] dst, input bit we, input logic [31:0] din);
        bit mis, ld;
        @(negedge clk);
        rst = r; stall = s; flush = f; ex_en = e; ex_mem_op = op; ex_addr_lo = lo;
        ex_pc = pc; ex_dst_addr = dst; ex_gpr_we = we; mem_out_in = din;
        mis = misal(e, op, lo);
        ld  = e && is_ld(op) && !mis;
        #1 chk("busy", 32'(mem_busy), 32'(!r && (m_wait > 0 || (ld && !f))));
        @(posedge clk);
        if (r) begin
            {m_en, m_we, m_exp, m_pc, m_out, m_dst} = '0;
            m_wait = 0;
        end else if (s) begin
            // hold everything
        end else if (m_wait == 0 && ld && !f) begin
            m_en = 0; m_we = 0; m_exp = 0;
            m_wait = WAIT_CYC;
        end else if (m_wait > 1 && !f) begin
            m_en = 0; m_we = 0; m_exp = 0;
            m_wait--;
        end else begin
            m_en = e; m_pc = pc; m_dst = dst; m_out = din;
            m_we = e && we && !mis; m_exp = mis;
            m_wait = 0;
            if (f) begin m_en = 0; m_we = 0; m_exp = 0; end
        end
        #1 chk_out();
    endtask

    initial begin
        bit          h_en, h_we;
        logic [3:0]  h_op;
        logic [1:0]  h_lo;
        logic [31:0] h_pc;
        logic [4:0]  h_dst;

        cyc(1, 0, 0, 0, MEMOP_NOP, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, MEMOP_LW, 0, 32'h55, 3, 1, 32'h77);
        chk("rst_en", 32'(mem_en), 0);
        chk("rst_pc", mem_pc, 0);

        // ALU op passes straight through
        cyc(0, 0, 0, 1, MEMOP_NOP, 0, 32'h40, 5, 1, 32'h1234);
        chk("alu_out", mem_out, 32'h1234);
        chk("alu_en", 32'(mem_en), 1);
        chk("alu_dst", 32'(mem_dst_addr), 5);

        // LW: bubble, then data at latency WAIT_CYC+1
        cyc(0, 0, 0, 1, MEMOP_LW, 0, 32'h44, 7, 1, 32'h0);
        chk("lw_bubble", 32'(mem_en), 0);
        for (int k = 0; k < WAIT_CYC; k++)
            cyc(0, 0, 0, 1, MEMOP_LW, 0, 32'h44, 7, 1, 32'hDEADBEEF);
        chk("lw_en", 32'(mem_en), 1);
        chk("lw_out", mem_out, 32'hDEADBEEF);
        cyc(0, 0, 0, 0, MEMOP_NOP, 0, 32'h48, 0, 0, 32'h0);

        // flush during LOAD_WAIT
        cyc(0, 0, 0, 1, MEMOP_LW, 0, 32'h50, 9, 1, 32'h1);
        cyc(0, 0, 1, 1, MEMOP_LW, 0, 32'h50, 9, 1, 32'h2);
        chk("flush_en", 32'(mem_en), 0);
        cyc(0, 0, 0, 0, MEMOP_NOP, 0, 32'h54, 0, 0, 32'h3);
        chk("flush_busy_next", 32'(mem_busy), 0);

        // stall beats flush
        cyc(0, 0, 0, 1, MEMOP_NOP, 0, 32'h100, 2, 1, 32'hAA);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 1, 1, MEMOP_SW, 0, 32'h200 + k, 4, 1, 32'hBB);
            chk("stall_pc", mem_pc, 32'h100);
            chk("stall_en", 32'(mem_en), 1);
        end

`ifdef MEM_MISALIGN_EN
        cyc(0, 0, 0, 1, MEMOP_LW, 2'b10, 32'h60, 6, 1, 32'hC);
        chk("mis_lw_exp", 32'(mem_exp), 1);
        chk("mis_lw_we", 32'(mem_gpr_we), 0);
        chk("mis_lw_busy", 32'(mem_busy), 0);
        cyc(0, 0, 0, 1, MEMOP_LH, 2'b10, 32'h64, 6, 1, 32'hD);
        for (int k = 0; k < WAIT_CYC; k++)
            cyc(0, 0, 0, 1, MEMOP_LH, 2'b10, 32'h64, 6, 1, 32'hD);
        chk("lh_exp", 32'(mem_exp), 0);
`endif

        // reset in the middle of a load
        cyc(0, 0, 0, 1, MEMOP_LW, 0, 32'h70, 8, 1, 32'hE);
        cyc(1, 0, 0, 1, MEMOP_LW, 0, 32'h70, 8, 1, 32'hF);
        chk("rstmid_busy", 32'(mem_busy), 0);
        chk("rstmid_out", mem_out, 0);
        chk("rstmid_en", 32'(mem_en), 0);

        h_en = 0; h_we = 0; h_op = 0; h_lo = 0; h_pc = 0; h_dst = 0;
        for (int i = 0; i < 500; i++) begin
            if (m_wait == 0) begin
                h_en  = $urandom_range(99) < 85;
                h_op  = $urandom_range(1) ? 4'($urandom_range(5, 1)) : 4'($urandom_range(8));
                h_lo  = 2'($urandom);
                h_pc  = $urandom;
                h_dst = 5'($urandom);
                h_we  = 1'($urandom);
            end
            cyc($urandom_range(99) < 2, $urandom_range(99) < 15, $urandom_range(99) < 8,
                h_en, h_op, h_lo, h_pc, h_dst, h_we, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_reg.md
MEM_REG -- requirements
Module: mem_reg

Interface
REQ-001 Parameter: WAIT_CYC, default 1, number of BRAM read-latency cycles a load waits (legal 1..3).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 stall  in  1  hold all pipeline outputs.
REQ-006 flush  in  1  invalidate the stage.
REQ-007 ex_en  in  1  valid instruction entering the MEM stage.
REQ-008 ex_mem_op  in  4  memory op code, `MEMOPBUS encoding.
REQ-009 ex_addr_lo  in  2  byte offset of the access address.
REQ-010 ex_pc  in  32  PC of the instruction.
REQ-011 ex_dst_addr  in  5  destination GPR index.
REQ-012 ex_gpr_we  in  1  GPR write enable, active-high.
REQ-013 mem_out_in  in  32  combinational result from the memory-control stage.
REQ-014 mem_en / mem_pc / mem_dst_addr / mem_gpr_we / mem_out  out  1/32/5/1/32  registered MEM/WB fields.
REQ-015 mem_busy  out  1  combinational upstream stall request while a load waits.
REQ-016 mem_exp  out  1  registered misalignment exception flag (macro-dependent).

Function
REQ-017 A load is ex_en=1 with ex_mem_op in {LW, LH, LHU, LB, LBU}; all other ops are non-loads.
REQ-018 FSM states: IDLE, LOAD_WAIT. IDLE->LOAD_WAIT on load when not stalled/flushed; LOAD_WAIT->IDLE when wait counter reaches WAIT_CYC.
REQ-019 Wait counter: 2 bits; cleared on entry to LOAD_WAIT; increments each cycle in LOAD_WAIT.
REQ-020 mem_busy SHALL be 1 in IDLE on an accepted load, and in LOAD_WAIT until the counter equals WAIT_CYC; it is 0 otherwise.
REQ-021 Non-loads: outputs capture inputs on the next edge (latency 1), with mem_en=ex_en.
REQ-022 Loads: outputs capture the inputs on the edge leaving LOAD_WAIT. Total latency SHALL be WAIT_CYC+1. mem_en SHALL be 0 on the intervening edges (bubble).
REQ-023 stall=1: all outputs, FSM state and counter hold, and mem_busy keeps its value.
REQ-024 flush=1 (no stall): mem_en=0, mem_gpr_we=0, mem_exp=0, and the FSM SHALL return to IDLE. flush overrides a load in progress.
REQ-025 stall and flush both 1: stall wins, hold.
REQ-026 ex_en=0: mem_en=0 and mem_gpr_we=0; other fields capture inputs.

Reset
REQ-027 On rst: all outputs 0, FSM=IDLE, counter=0; rst overrides stall and flush.
REQ-028 rst asserted mid-load SHALL abandon the load with no output update.

Configuration
REQ-029 Macro MEM_MISALIGN_EN.
REQ-030 Defined: a misaligned access is ex_en=1 with either (word op and ex_addr_lo!=0) or (half op and ex_addr_lo[0]=1).
REQ-031 Defined, on a misaligned access: mem_exp=1 with latency 1, mem_gpr_we=0, and no LOAD_WAIT entry.
REQ-032 Undefined: mem_exp is tied 0, and no misalignment logic is present.

Structure
REQ-033 The MEMOP codes, op width, word width, GPR index width and state encodings belong in the shared bus/signal headers package.
REQ-034 One sub-module, mem_misalign_chk, is a combinational checker; it is instantiated only under MEM_MISALIGN_EN.

Verification
REQ-035 ALU op, ex_en=1, mem_out_in=32'h1234, dst=5 -> next edge mem_en=1, mem_out=32'h1234, mem_dst_addr=5, mem_busy=0.
REQ-036 LW, WAIT_CYC=1, mem_out_in=32'hDEADBEEF -> mem_busy=1 for 2 cycles, then mem_en=1 with mem_out=32'hDEADBEEF at latency 2, and a bubble before it.
REQ-037 LW in LOAD_WAIT, flush=1 -> FSM IDLE, mem_en=0, mem_busy=0 next cycle.
REQ-038 stall=1 and flush=1 for 3 cycles after loading PC 32'h100 -> mem_pc stays 32'h100 and mem_en stays 1.
REQ-039 With MEM_MISALIGN_EN: LW with addr_lo=2'b10 -> mem_exp=1, mem_gpr_we=0, mem_busy=0; LH with 2'b10 -> mem_exp=0.
REQ-040 rst asserted during LOAD_WAIT -> next edge all outputs 0 and mem_busy=0.
